// File: rtl/eif_pkg.sv
// Shared types and helpers for the EIF neuron scheduler slice.
package eif_pkg;

  localparam int unsigned STATE_W_DEF = 8;
  localparam int unsigned CUR_W_DEF   = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_SKIP
  } sched_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/eif_spike_fifo.sv
// Spike event FIFO; an extra pointer bit separates full from empty.
module eif_spike_fifo
  import eif_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [AW:0]  wr_q, rd_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_pop, do_push;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees the slot the push needs
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/eif_neuron_scheduler.sv
// Round-robin scheduler sharing one EIF update datapath across N virtual neurons.
module eif_neuron_scheduler
  import eif_pkg::*;
#(
  parameter int unsigned N_NEURONS  = 4,
  parameter int unsigned STATE_W    = STATE_W_DEF,
  parameter int unsigned CUR_W      = CUR_W_DEF,
  parameter int unsigned REFRAC     = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned V_RESET    = 0,
  localparam int unsigned IW        = clog2(N_NEURONS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               cfg_we,
  input  logic [IW-1:0]      cfg_addr,
  input  logic [CUR_W-1:0]   cfg_data,
  output logic               dp_req,
  input  logic               dp_gnt,
  output logic [STATE_W-1:0] dp_state,
  output logic [CUR_W-1:0]   dp_current,
  input  logic               dp_rvalid,
  input  logic [STATE_W-1:0] dp_rstate,
  input  logic               dp_rspike,
  output logic               spk_valid,
  input  logic               spk_ready,
  output logic [IW-1:0]      spk_id,
  output logic               busy,
  output logic               tick_miss,
  output logic               spk_ovf
);

  localparam int unsigned RW_RAW = clog2(REFRAC + 1);
  localparam int unsigned RW     = (RW_RAW > 0) ? RW_RAW : 1;
  localparam logic [STATE_W-1:0] VR = STATE_W'(V_RESET);

  sched_state_e        fsm_q, fsm_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [STATE_W-1:0]  mem_q [N_NEURONS];
  logic [CUR_W-1:0]    cur_q [N_NEURONS];
  logic [RW-1:0]       ref_q [N_NEURONS];
  logic [STATE_W-1:0]  op_state_q, res_state_q;
  logic [CUR_W-1:0]    op_cur_q;
  logic                res_spike_q, tick_miss_q, spk_ovf_q;
  logic                push, pop, fifo_full, fifo_empty;

  always_comb begin
    fsm_d = fsm_q;
    idx_d = idx_q;
    case (fsm_q)
      S_IDLE:  if (tick) begin
                 idx_d = '0;
                 fsm_d = S_FETCH;
               end
      S_FETCH: fsm_d = (ref_q[idx_q] != '0) ? S_SKIP : S_ISSUE;
      S_ISSUE: if (dp_gnt) fsm_d = S_WAIT;
      S_WAIT:  if (dp_rvalid) fsm_d = S_WRITE;
      S_WRITE, S_SKIP: begin
        if (idx_q == IW'(N_NEURONS - 1)) begin
          fsm_d = S_IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
          fsm_d = S_FETCH;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  // operands are latched at FETCH so config writes cannot disturb an in-flight request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= S_IDLE;
      idx_q       <= '0;
      op_state_q  <= '0;
      op_cur_q    <= '0;
      res_state_q <= '0;
      res_spike_q <= 1'b0;
      tick_miss_q <= 1'b0;
      spk_ovf_q   <= 1'b0;
      for (int unsigned i = 0; i < N_NEURONS; i++) begin
        mem_q[i] <= VR;
        cur_q[i] <= '0;
        ref_q[i] <= '0;
      end
    end else begin
      fsm_q <= fsm_d;
      idx_q <= idx_d;
      if (cfg_we) cur_q[cfg_addr] <= cfg_data;
      if (fsm_q == S_FETCH) begin
        op_state_q <= mem_q[idx_q];
        op_cur_q   <= cur_q[idx_q];
      end
      if (fsm_q == S_WAIT && dp_rvalid) begin
        res_state_q <= dp_rstate;
        res_spike_q <= dp_rspike;
      end
      if (fsm_q == S_WRITE) begin
        if (res_spike_q) begin
          mem_q[idx_q] <= VR;
          ref_q[idx_q] <= RW'(REFRAC);
        end else begin
          mem_q[idx_q] <= res_state_q;
        end
      end
      if (fsm_q == S_SKIP && ref_q[idx_q] != '0) ref_q[idx_q] <= ref_q[idx_q] - 1'b1;
      if (tick && fsm_q != S_IDLE) tick_miss_q <= 1'b1;
      if (push && fifo_full && !pop) spk_ovf_q <= 1'b1;
    end
  end

  assign push       = (fsm_q == S_WRITE) && res_spike_q;
  assign pop        = spk_valid && spk_ready;
  assign dp_req     = (fsm_q == S_ISSUE);
  assign dp_state   = dp_req ? op_state_q : '0;
  assign dp_current = dp_req ? op_cur_q : '0;
  assign busy       = (fsm_q != S_IDLE);
  assign spk_valid  = !fifo_empty;
  assign tick_miss  = tick_miss_q;
  assign spk_ovf    = spk_ovf_q;

  eif_spike_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (IW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (idx_q),
    .dout  (spk_id),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_eif_neuron_scheduler.sv
// Directed bench: instance 0 has REFRAC=2, instance 1 has REFRAC=0.
module tb_eif_neuron_scheduler;

  localparam int IW = 2;
  localparam int SW = 8;
  localparam int CW = 8;
  localparam logic [CW-1:0] SPK_THR = 8'd50;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0] tick, cfg_we, dp_req, dp_gnt, dp_rvalid, dp_rspike;
  logic [1:0] spk_valid, spk_ready, busy, tick_miss, spk_ovf;
  logic [1:0] rdy_force, rdy_wr, rdy_on_write;
  logic [1:0][IW-1:0] cfg_addr, spk_id;
  logic [1:0][CW-1:0] cfg_data, dp_current;
  logic [1:0][SW-1:0] dp_state;
  logic [1:0][SW-1:0] dp_rstate = '0;

  logic [1:0]    pend = '0;
  logic [1:0]    wr_next = '0;
  int            cnt [2];
  int            lat [2];
  int            req_cnt [2];
  logic [SW-1:0] st [2];
  logic [CW-1:0] cu [2];
  logic [SW-1:0] log_st [2][64];
  logic [CW-1:0] log_cur [2][64];
  logic [IW-1:0] drained_id [16];
  int            drained_n;

  int n_pass = 0;
  int n_total = 0;

  assign spk_ready = rdy_force | rdy_wr;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    eif_neuron_scheduler #(
      .N_NEURONS  (4),
      .STATE_W    (SW),
      .CUR_W      (CW),
      .REFRAC     (g == 0 ? 2 : 0),
      .FIFO_DEPTH (4),
      .V_RESET    (0)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick[g]),
      .cfg_we     (cfg_we[g]),
      .cfg_addr   (cfg_addr[g]),
      .cfg_data   (cfg_data[g]),
      .dp_req     (dp_req[g]),
      .dp_gnt     (dp_gnt[g]),
      .dp_state   (dp_state[g]),
      .dp_current (dp_current[g]),
      .dp_rvalid  (dp_rvalid[g]),
      .dp_rstate  (dp_rstate[g]),
      .dp_rspike  (dp_rspike[g]),
      .spk_valid  (spk_valid[g]),
      .spk_ready  (spk_ready[g]),
      .spk_id     (spk_id[g]),
      .busy       (busy[g]),
      .tick_miss  (tick_miss[g]),
      .spk_ovf    (spk_ovf[g])
    );
  end

  // datapath model: grant immediately, answer lat cycles later, spike on large current
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      dp_gnt[g] = 1'b0;
      dp_rvalid[g] = 1'b0;
      dp_rspike[g] = 1'b0;
      rdy_wr[g] = 1'b0;
      if (wr_next[g]) begin
        rdy_wr[g] = rdy_on_write[g];
        wr_next[g] = 1'b0;
      end
      if (pend[g]) begin
        if (cnt[g] == 0) begin
          dp_rvalid[g] = 1'b1;
          dp_rstate[g] = st[g] + cu[g];
          dp_rspike[g] = (cu[g] >= SPK_THR);
          pend[g] = 1'b0;
          wr_next[g] = 1'b1;
        end else begin
          cnt[g]--;
        end
      end else if (dp_req[g] === 1'b1) begin
        dp_gnt[g] = 1'b1;
        pend[g] = 1'b1;
        cnt[g] = lat[g];
        st[g] = dp_state[g];
        cu[g] = dp_current[g];
        log_st[g][req_cnt[g] % 64] = st[g];
        log_cur[g][req_cnt[g] % 64] = cu[g];
        req_cnt[g]++;
      end
    end
  end

  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      tick[i] = 1'b0;
      cfg_we[i] = 1'b0;
      cfg_addr[i] = '0;
      cfg_data[i] = '0;
      rdy_force[i] = 1'b0;
      rdy_on_write[i] = 1'b0;
      lat[i] = 0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic cfg(input int i, input int a, input int d);
    cfg_we[i] = 1'b1;
    cfg_addr[i] = IW'(a);
    cfg_data[i] = CW'(d);
    @(negedge clk);
    cfg_we[i] = 1'b0;
  endtask

  task automatic do_tick(input int i);
    tick[i] = 1'b1;
    @(negedge clk);
    tick[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (busy[i] === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic drain(input int i);
    drained_n = 0;
    rdy_force[i] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (spk_valid[i] === 1'b1) begin
        drained_id[drained_n] = spk_id[i];
        drained_n++;
      end
      @(negedge clk);
    end
    rdy_force[i] = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      n_total++;
      if ({dp_req[i], dp_state[i], dp_current[i], spk_valid[i], spk_id[i],
           busy[i], tick_miss[i], spk_ovf[i]} !== '0)
        $display("FAIL reset_outputs[%0d]: got req=%b st=%0d cur=%0d sv=%b id=%0d busy=%b tm=%b ovf=%b expected all 0",
                 i, dp_req[i], dp_state[i], dp_current[i], spk_valid[i], spk_id[i],
                 busy[i], tick_miss[i], spk_ovf[i]);
      else n_pass++;
    end
  endtask

  task automatic test_sweep();
    int b;
    bit ok;
    for (int n = 0; n < 4; n++) cfg(0, n, 10);
    b = req_cnt[0];
    do_tick(0);
    wait_idle(0, 100, ok);
    n_total++;
    if (ok !== 1'b1) $display("FAIL sweep_done: got busy=%b expected 0 within budget", busy[0]); else n_pass++;
    n_total++;
    if (req_cnt[0] - b !== 4) $display("FAIL sweep_reqs: got %0d expected 4", req_cnt[0] - b); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (log_st[0][(b + k) % 64] !== 8'd0 || log_cur[0][(b + k) % 64] !== 8'd10)
        $display("FAIL sweep_req%0d: got st=%0d cur=%0d expected st=0 cur=10",
                 k, log_st[0][(b + k) % 64], log_cur[0][(b + k) % 64]);
      else n_pass++;
    end
    for (int n = 0; n < 4; n++) cfg(0, n, n + 1);
    b = req_cnt[0];
    do_tick(0);
    wait_idle(0, 100, ok);
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (log_st[0][(b + k) % 64] !== 8'd10 || log_cur[0][(b + k) % 64] !== CW'(k + 1))
        $display("FAIL sweep_order%0d: got st=%0d cur=%0d expected st=10 cur=%0d",
                 k, log_st[0][(b + k) % 64], log_cur[0][(b + k) % 64], k + 1);
      else n_pass++;
    end
    n_total++;
    if (tick_miss[0] !== 1'b0 || spk_valid[0] !== 1'b0)
      $display("FAIL sweep_flags: got tm=%b sv=%b expected 0 0", tick_miss[0], spk_valid[0]);
    else n_pass++;
  endtask

  task automatic test_refractory();
    int b;
    bit ok;
    int ec [3] = '{1, 2, 3};
    int es [2][3] = '{'{1, 2, 3}, '{2, 4, 6}};
    do_reset();
    cfg(0, 0, 1);
    cfg(0, 1, 2);
    cfg(0, 2, 60);
    cfg(0, 3, 3);
    b = req_cnt[0];
    do_tick(0);
    wait_idle(0, 100, ok);
    n_total++;
    if (req_cnt[0] - b !== 4 || spk_valid[0] !== 1'b1 || spk_id[0] !== 2'd2)
      $display("FAIL refrac_tick1: got reqs=%0d sv=%b id=%0d expected 4 1 2", req_cnt[0] - b, spk_valid[0], spk_id[0]);
    else n_pass++;
    for (int t = 0; t < 2; t++) begin
      b = req_cnt[0];
      do_tick(0);
      wait_idle(0, 100, ok);
      n_total++;
      if (req_cnt[0] - b !== 3) $display("FAIL refrac_skip_t%0d: got %0d reqs expected 3", t + 2, req_cnt[0] - b); else n_pass++;
      for (int k = 0; k < 3; k++) begin
        n_total++;
        if (log_cur[0][(b + k) % 64] !== CW'(ec[k]) || log_st[0][(b + k) % 64] !== SW'(es[t][k]))
          $display("FAIL refrac_t%0d_req%0d: got cur=%0d st=%0d expected cur=%0d st=%0d",
                   t + 2, k, log_cur[0][(b + k) % 64], log_st[0][(b + k) % 64], ec[k], es[t][k]);
        else n_pass++;
      end
    end
    drain(0);
    n_total++;
    if (drained_n !== 1 || drained_id[0] !== 2'd2)
      $display("FAIL refrac_events: got n=%0d first=%0d expected n=1 id=2", drained_n, drained_id[0]);
    else n_pass++;
    b = req_cnt[0];
    do_tick(0);
    wait_idle(0, 100, ok);
    n_total++;
    if (req_cnt[0] - b !== 4 || log_st[0][(b + 2) % 64] !== 8'd0 || log_cur[0][(b + 2) % 64] !== 8'd60)
      $display("FAIL refrac_resume: got reqs=%0d st2=%0d cur2=%0d expected 4 0 60",
               req_cnt[0] - b, log_st[0][(b + 2) % 64], log_cur[0][(b + 2) % 64]);
    else n_pass++;
  endtask

  task automatic test_overflow();
    bit ok;
    do_reset();
    for (int n = 0; n < 4; n++) cfg(1, n, 99);
    do_tick(1);
    wait_idle(1, 100, ok);
    n_total++;
    if (spk_ovf[1] !== 1'b0 || spk_valid[1] !== 1'b1)
      $display("FAIL ovf_exact_full: got ovf=%b sv=%b expected 0 1", spk_ovf[1], spk_valid[1]);
    else n_pass++;
    do_tick(1);
    wait_idle(1, 100, ok);
    n_total++;
    if (spk_ovf[1] !== 1'b1 || spk_id[1] !== 2'd0)
      $display("FAIL ovf_set: got ovf=%b id=%0d expected 1 0", spk_ovf[1], spk_id[1]);
    else n_pass++;
    drain(1);
    n_total++;
    if (drained_n !== 4) $display("FAIL ovf_held: got %0d events expected 4", drained_n); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (drained_id[k] !== IW'(k)) $display("FAIL ovf_id%0d: got %0d expected %0d", k, drained_id[k], k); else n_pass++;
    end
  endtask

  task automatic test_tick_miss();
    int b;
    bit ok;
    do_reset();
    for (int n = 0; n < 4; n++) cfg(0, n, 10);
    lat[0] = 20;
    b = req_cnt[0];
    do_tick(0);
    repeat (2) @(negedge clk);
    n_total++;
    if (tick_miss[0] !== 1'b0) $display("FAIL miss_before: got %b expected 0", tick_miss[0]); else n_pass++;
    do_tick(0);
    n_total++;
    if (tick_miss[0] !== 1'b1) $display("FAIL miss_set: got %b expected 1", tick_miss[0]); else n_pass++;
    wait_idle(0, 200, ok);
    n_total++;
    if (ok !== 1'b1) $display("FAIL miss_sweep_done: got busy=%b expected 0 within budget", busy[0]); else n_pass++;
    repeat (10) @(negedge clk);
    n_total++;
    if (busy[0] !== 1'b0 || req_cnt[0] - b !== 4 || tick_miss[0] !== 1'b1)
      $display("FAIL miss_no_second: got busy=%b reqs=%0d tm=%b expected 0 4 1", busy[0], req_cnt[0] - b, tick_miss[0]);
    else n_pass++;
    lat[0] = 0;
  endtask

  task automatic test_back_to_back();
    int b;
    do_reset();
    for (int n = 0; n < 4; n++) cfg(0, n, 5);
    b = req_cnt[0];
    do_tick(0);
    repeat (15) @(negedge clk);
    n_total++;
    if (busy[0] !== 1'b1) $display("FAIL b2b_last_write_busy: got %b expected 1", busy[0]); else n_pass++;
    do_tick(0);
    n_total++;
    if (busy[0] !== 1'b0) $display("FAIL b2b_busy_fall: got %b expected 0", busy[0]); else n_pass++;
    repeat (4) @(negedge clk);
    n_total++;
    if (busy[0] !== 1'b0 || req_cnt[0] - b !== 4)
      $display("FAIL b2b_no_restart: got busy=%b reqs=%0d expected 0 4", busy[0], req_cnt[0] - b);
    else n_pass++;
  endtask

  task automatic test_rst_mid_wait();
    int b;
    bit ok;
    do_reset();
    for (int n = 0; n < 4; n++) cfg(0, n, (n == 1) ? 99 : 10);
    lat[0] = 6;
    b = req_cnt[0];
    do_tick(0);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (req_cnt[0] - b >= 2) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_total++;
    if (ok !== 1'b1) $display("FAIL rst_reach_wait: got %0d reqs expected 2", req_cnt[0] - b); else n_pass++;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_total++;
    if ({dp_req[0], dp_state[0], dp_current[0], spk_valid[0], spk_id[0],
         busy[0], tick_miss[0], spk_ovf[0]} !== '0)
      $display("FAIL rst_async_outputs: got req=%b busy=%b sv=%b expected all 0", dp_req[0], busy[0], spk_valid[0]);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    lat[0] = 0;
    repeat (12) @(negedge clk);
    n_total++;
    if (busy[0] !== 1'b0 || spk_valid[0] !== 1'b0 || dp_req[0] !== 1'b0)
      $display("FAIL rst_late_rvalid: got busy=%b sv=%b req=%b expected 0 0 0", busy[0], spk_valid[0], dp_req[0]);
    else n_pass++;
    b = req_cnt[0];
    do_tick(0);
    wait_idle(0, 100, ok);
    n_total++;
    if (req_cnt[0] - b !== 4 || log_st[0][(b + 1) % 64] !== 8'd0 || log_cur[0][(b + 1) % 64] !== 8'd0)
      $display("FAIL rst_cleared_regs: got reqs=%0d st1=%0d cur1=%0d expected 4 0 0",
               req_cnt[0] - b, log_st[0][(b + 1) % 64], log_cur[0][(b + 1) % 64]);
    else n_pass++;
  endtask

  task automatic test_full_push_pop();
    bit ok;
    do_reset();
    for (int n = 0; n < 4; n++) cfg(1, n, 99);
    do_tick(1);
    wait_idle(1, 100, ok);
    rdy_on_write[1] = 1'b1;
    do_tick(1);
    wait_idle(1, 100, ok);
    rdy_on_write[1] = 1'b0;
    @(negedge clk);
    n_total++;
    if (spk_ovf[1] !== 1'b0) $display("FAIL pushpop_ovf: got %b expected 0", spk_ovf[1]); else n_pass++;
    drain(1);
    n_total++;
    if (drained_n !== 4) $display("FAIL pushpop_count: got %0d expected 4", drained_n); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (drained_id[k] !== IW'(k)) $display("FAIL pushpop_id%0d: got %0d expected %0d", k, drained_id[k], k); else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1;
    do_reset();
    test_reset();
    test_sweep();
    test_refractory();
    test_overflow();
    test_tick_miss();
    test_back_to_back();
    test_rst_mid_wait();
    test_full_push_pop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
